zap_writeback_sequencer: RTL

- Final pipeline stage; sits directly downstream of the memory stage and consumes its registered outputs.
- Drives the single register-file write port.
- Splits instructions that carry both an ALU result and load data into two write cycles.
- Resolves exceptions and PC writes, and generates the pipeline clear and redirect.

---
 rtl/zap_writeback_sequencer_pkg.sv | 24 ++
 rtl/zap_writeback_sequencer_exc_prio.sv | 29 ++
 rtl/zap_writeback_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/zap_writeback_sequencer_pkg.sv
// Shared definitions for the writeback sequencer.
// Contents: default geometry, exception codes and FSM state encoding.
package zap_writeback_sequencer_pkg;

    localparam int unsigned FLAG_WDT_DEF = 32;
    localparam int unsigned PHY_REGS_DEF = 46;
    localparam int unsigned PHY_PC_DEF   = 15;
    localparam int unsigned PHY_RAZ_DEF  = 45;

    localparam logic [2:0] EXC_NONE = 3'd0;
    localparam logic [2:0] EXC_DABT = 3'd1;
    localparam logic [2:0] EXC_FIQ  = 3'd2;
    localparam logic [2:0] EXC_IRQ  = 3'd3;
    localparam logic [2:0] EXC_PABT = 3'd4;
    localparam logic [2:0] EXC_UND  = 3'd5;
    localparam logic [2:0] EXC_SWI  = 3'd6;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_LOAD2 = 2'd1,
        S_FLUSH = 2'd2
    } wb_state_e;

endpackage

// File: rtl/zap_writeback_sequencer_exc_prio.sv
// zap_wb_exc_prio: combinational exception priority encoder.
// Ports: six exception flags in; o_valid (any flag) and o_code out.
// Priority: mem_fault > fiq > irq > instr_abort > und > swi.
module zap_wb_exc_prio
    import zap_writeback_sequencer_pkg::*;
(
    input  logic       i_mem_fault,
    input  logic       i_fiq,
    input  logic       i_irq,
    input  logic       i_instr_abort,
    input  logic       i_und,
    input  logic       i_swi,
    output logic       o_valid,
    output logic [2:0] o_code
);

    always_comb begin
        o_code  = EXC_NONE;
        o_valid = 1'b1;
        if (i_mem_fault)        o_code = EXC_DABT;
        else if (i_fiq)         o_code = EXC_FIQ;
        else if (i_irq)         o_code = EXC_IRQ;
        else if (i_instr_abort) o_code = EXC_PABT;
        else if (i_und)         o_code = EXC_UND;
        else if (i_swi)         o_code = EXC_SWI;
        else                    o_valid = 1'b0;
    end

endmodule

// File: rtl/zap_writeback_sequencer.sv
// zap_writeback_sequencer: final pipeline stage driving the register-file
// write port. Splits load-with-writeback into two writes, converts PC writes
// into a fetch redirect plus pipeline clear, and takes exceptions.
// Inputs : registered memory-stage outputs (i_*_ff), load data, exception flags,
//          i_code_stall global freeze, i_reset synchronous active-high.
// Outputs: o_wen/o_wr_index/o_wr_data write port, o_flags_ff, o_stall (comb),
//          o_clear, o_pc_redirect/o_pc_target, o_exc_valid/o_exc_code/o_exc_lr.
// Optional: define ZAP_WB_RETIRE_COUNT_EN to add the o_retire_count counter.
module zap_writeback_sequencer
    import zap_writeback_sequencer_pkg::*;
#(
    parameter int unsigned FLAG_WDT = FLAG_WDT_DEF,
    parameter int unsigned PHY_REGS = PHY_REGS_DEF,
    parameter int unsigned PHY_PC   = PHY_PC_DEF,
    parameter int unsigned PHY_RAZ  = PHY_RAZ_DEF,
    localparam int unsigned IW      = $clog2(PHY_REGS)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_code_stall,
    input  logic                i_dav_ff,
    input  logic [31:0]         i_alu_result_ff,
    input  logic [FLAG_WDT-1:0] i_flags_ff,
    input  logic [IW-1:0]       i_destination_index_ff,
    input  logic                i_mem_load_ff,
    input  logic [31:0]         i_mem_rd_data,
    input  logic [IW-1:0]       i_mem_srcdest_index_ff,
    input  logic [31:0]         i_pc_plus_8_ff,
    input  logic                i_irq_ff,
    input  logic                i_fiq_ff,
    input  logic                i_swi_ff,
    input  logic                i_instr_abort_ff,
    input  logic                i_und_ff,
    input  logic                i_mem_fault,
    output logic                o_wen,
    output logic [IW-1:0]       o_wr_index,
    output logic [31:0]         o_wr_data,
    output logic [FLAG_WDT-1:0] o_flags_ff,
    output logic                o_stall,
    output logic                o_clear,
    output logic                o_pc_redirect,
    output logic [31:0]         o_pc_target,
    output logic                o_exc_valid,
    output logic [2:0]          o_exc_code,
    output logic [31:0]         o_exc_lr
`ifdef ZAP_WB_RETIRE_COUNT_EN
    ,
    output logic [31:0]         o_retire_count
`endif
);

    localparam logic [IW-1:0] IDX_PC  = IW'(PHY_PC);
    localparam logic [IW-1:0] IDX_RAZ = IW'(PHY_RAZ);

    wb_state_e     state_q;
    logic [31:0]   ld_data_q;
    logic [IW-1:0] ld_idx_q;
    // ALU half of a dual wrote PC: redirect is deferred until the load lands
    logic          pc_pend_q;
    logic [31:0]   pc_tgt_q;

    logic          exc_any;
    logic [2:0]    exc_code;
    logic          dual;
    logic [IW-1:0] single_idx;
    logic [31:0]   single_data;

    zap_wb_exc_prio u_exc_prio (
        .i_mem_fault   (i_mem_fault),
        .i_fiq         (i_fiq_ff),
        .i_irq         (i_irq_ff),
        .i_instr_abort (i_instr_abort_ff),
        .i_und         (i_und_ff),
        .i_swi         (i_swi_ff),
        .o_valid       (exc_any),
        .o_code        (exc_code)
    );

    assign dual = i_mem_load_ff
               && (i_destination_index_ff != IDX_RAZ)
               && (i_mem_srcdest_index_ff != IDX_RAZ)
               && (i_destination_index_ff != i_mem_srcdest_index_ff);

    // A load always targets srcdest, which also covers equal indices.
    assign single_idx  = i_mem_load_ff ? i_mem_srcdest_index_ff : i_destination_index_ff;
    assign single_data = i_mem_load_ff ? i_mem_rd_data : i_alu_result_ff;

    // Hold the memory stage while the first half of a dual is written.
    assign o_stall = (state_q == S_RUN) && i_dav_ff && !exc_any && dual;

`ifdef ZAP_WB_RETIRE_COUNT_EN
    logic [31:0] retire_q;
    assign o_retire_count = retire_q;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= S_RUN;
            ld_data_q     <= 32'd0;
            ld_idx_q      <= IDX_RAZ;
            pc_pend_q     <= 1'b0;
            pc_tgt_q      <= 32'd0;
            o_wen         <= 1'b0;
            o_wr_index    <= IDX_RAZ;
            o_wr_data     <= 32'd0;
            o_flags_ff    <= '0;
            o_clear       <= 1'b0;
            o_pc_redirect <= 1'b0;
            o_pc_target   <= 32'd0;
            o_exc_valid   <= 1'b0;
            o_exc_code    <= EXC_NONE;
            o_exc_lr      <= 32'd0;
`ifdef ZAP_WB_RETIRE_COUNT_EN
            retire_q      <= 32'd0;
`endif
        end else if (!i_code_stall) begin
            o_wen         <= 1'b0;
            o_wr_index    <= IDX_RAZ;
            o_clear       <= 1'b0;
            o_pc_redirect <= 1'b0;
            o_exc_valid   <= 1'b0;
            case (state_q)
                S_RUN: begin
                    if (i_dav_ff) begin
                        if (exc_any) begin
                            o_exc_valid <= 1'b1;
                            o_exc_code  <= exc_code;
                            o_exc_lr    <= i_pc_plus_8_ff - 32'd4;
                            o_clear     <= 1'b1;
                            state_q     <= S_FLUSH;
                        end else if (dual) begin
                            o_flags_ff <= i_flags_ff;
                            ld_data_q  <= i_mem_rd_data;
                            ld_idx_q   <= i_mem_srcdest_index_ff;
                            if (i_destination_index_ff == IDX_PC) begin
                                pc_pend_q <= 1'b1;
                                pc_tgt_q  <= i_alu_result_ff;
                            end else begin
                                o_wen      <= 1'b1;
                                o_wr_index <= i_destination_index_ff;
                                o_wr_data  <= i_alu_result_ff;
                            end
                            state_q <= S_LOAD2;
                        end else begin
                            o_flags_ff <= i_flags_ff;
`ifdef ZAP_WB_RETIRE_COUNT_EN
                            retire_q   <= retire_q + 32'd1;
`endif
                            if (single_idx == IDX_PC) begin
                                o_pc_redirect <= 1'b1;
                                o_pc_target   <= single_data;
                                o_clear       <= 1'b1;
                                state_q       <= S_FLUSH;
                            end else if (single_idx != IDX_RAZ) begin
                                o_wen      <= 1'b1;
                                o_wr_index <= single_idx;
                                o_wr_data  <= single_data;
                            end
                        end
                    end
                end
                S_LOAD2: begin
                    // Inputs are the held instruction; only latched state is used.
                    pc_pend_q <= 1'b0;
`ifdef ZAP_WB_RETIRE_COUNT_EN
                    retire_q  <= retire_q + 32'd1;
`endif
                    if (ld_idx_q == IDX_PC) begin
                        o_pc_redirect <= 1'b1;
                        o_pc_target   <= ld_data_q;
                        o_clear       <= 1'b1;
                        state_q       <= S_FLUSH;
                    end else begin
                        o_wen      <= 1'b1;
                        o_wr_index <= ld_idx_q;
                        o_wr_data  <= ld_data_q;
                        if (pc_pend_q) begin
                            o_pc_redirect <= 1'b1;
                            o_pc_target   <= pc_tgt_q;
                            o_clear       <= 1'b1;
                            state_q       <= S_FLUSH;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_FLUSH: state_q <= S_RUN;
                default: state_q <= S_RUN;
            endcase
        end
    end

endmodule
